// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL reference startup sequencer.
package pll_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    REF_ON  = 3'd1,
    SETTLE  = 3'd2,
    ACQUIRE = 3'd3,
    LOCKED  = 3'd4,
    RETRY   = 3'd5,
    FAIL    = 3'd6
  } state_e;

  // Bits needed to hold a counter whose largest value is 'term' (minimum 1).
  function automatic int cnt_width(input int term);
    return (term < 1) ? 1 : $clog2(term + 1);
  endfunction

endpackage

// File: rtl/pll_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module pll_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the input through two flops; both clear to 0 on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_ref_startup_seq.sv
// Startup / relock sequencer for the PLL reference path.
// Enables the reference, lets it settle, releases divider and charge pump,
// qualifies lock over a window and retries a bounded number of times.
module pll_ref_startup_seq
  import pll_seq_pkg::*;
#(
  parameter int SETTLE_CYC       = 64,
  parameter int LOCK_WIN_CYC     = 256,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int UNLOCK_CYC       = 8,
  parameter int MAX_RETRY        = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           lock_raw,
  output logic                           ref_en,
  output logic                           div_rst_n,
  output logic                           cp_en,
  output logic                           locked,
  output logic                           fail,
  output logic                           busy,
  output logic [2:0]                     state,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);

  localparam int SET_W  = cnt_width(SETTLE_CYC - 1);
  localparam int LOCK_W = cnt_width(LOCK_WIN_CYC - 1);
  localparam int TMO_W  = cnt_width(LOCK_TIMEOUT_CYC - 1);
  localparam int UNL_W  = cnt_width(UNLOCK_CYC - 1);
  localparam int RET_W  = $clog2(MAX_RETRY + 1);

  localparam logic [SET_W-1:0]  SETTLE_TC = SET_W'(SETTLE_CYC - 1);
  localparam logic [LOCK_W-1:0] LOCK_TC   = LOCK_W'(LOCK_WIN_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_TC    = TMO_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [UNL_W-1:0]  UNL_TC    = UNL_W'(UNLOCK_CYC - 1);
  localparam logic [RET_W-1:0]  RETRY_MAX = RET_W'(MAX_RETRY);

  state_e            state_q, state_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [UNL_W-1:0]  unl_q, unl_d;
  logic [RET_W-1:0]  retry_q, retry_d;
  logic              lock_s;

  pll_sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (lock_raw),
    .q     (lock_s)
  );

  // State and counter registers; everything returns to IDLE/0 on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      lock_q   <= '0;
      tmo_q    <= '0;
      unl_q    <= '0;
      retry_q  <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      lock_q   <= lock_d;
      tmo_q    <= tmo_d;
      unl_q    <= unl_d;
      retry_q  <= retry_d;
    end
  end

  // Next-state and counter updates; dropping start aborts from anywhere but FAIL.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    lock_d   = lock_q;
    tmo_d    = tmo_q;
    unl_d    = unl_q;
    retry_d  = retry_q;

    if (!start && state_q != FAIL) begin
      state_d  = IDLE;
      settle_d = '0;
      lock_d   = '0;
      tmo_d    = '0;
      unl_d    = '0;
      retry_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = REF_ON;
          retry_d = '0;
        end
        REF_ON: begin
          state_d  = SETTLE;
          settle_d = '0;
        end
        SETTLE, RETRY: begin
          if (settle_q == SETTLE_TC) begin
            state_d = ACQUIRE;
            lock_d  = '0;
            tmo_d   = '0;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        ACQUIRE: begin
          if (lock_s && lock_q == LOCK_TC) begin
            state_d = LOCKED;
            unl_d   = '0;
          end else if (tmo_q == TMO_TC) begin
            if (retry_q < RETRY_MAX) begin
              state_d  = RETRY;
              retry_d  = retry_q + 1'b1;
              settle_d = '0;
            end else begin
              state_d = FAIL;
            end
          end else begin
            if (!lock_s) lock_d = '0;
            else if (lock_q != LOCK_TC) lock_d = lock_q + 1'b1;
            tmo_d = tmo_q + 1'b1;
          end
        end
        LOCKED: begin
          if (lock_s) begin
            unl_d = '0;
          end else if (unl_q == UNL_TC) begin
            if (retry_q == RETRY_MAX) begin
              state_d = FAIL;
            end else begin
              state_d  = RETRY;
              retry_d  = retry_q + 1'b1;
              settle_d = '0;
            end
          end else begin
            unl_d = unl_q + 1'b1;
          end
        end
        FAIL: begin
          if (!start) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Moore output decode straight from the state register.
  always_comb begin
    ref_en    = 1'b0;
    div_rst_n = 1'b0;
    cp_en     = 1'b0;
    locked    = 1'b0;
    fail      = 1'b0;
    busy      = 1'b0;
    case (state_q)
      REF_ON, SETTLE, RETRY: begin
        ref_en = 1'b1;
        busy   = 1'b1;
      end
      ACQUIRE: begin
        ref_en    = 1'b1;
        div_rst_n = 1'b1;
        cp_en     = 1'b1;
        busy      = 1'b1;
      end
      LOCKED: begin
        ref_en    = 1'b1;
        div_rst_n = 1'b1;
        cp_en     = 1'b1;
        locked    = 1'b1;
      end
      FAIL: fail = 1'b1;
      default: ;
    endcase
  end

  assign state     = state_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_ref_startup_seq.sv
// Directed bench for pll_ref_startup_seq with small counts so every scenario
// fits in a few hundred cycles. Expected values are hand-derived edge numbers.
module tb_pll_ref_startup_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       lock_raw;
  logic       ref_en, div_rst_n, cp_en, locked, fail, busy;
  logic [2:0] state;
  logic [1:0] retry_cnt;
  logic [5:0] outs;

  int vec  = 0;
  int errs = 0;
  int cur  = 0;

  // {ref_en, div_rst_n, cp_en, locked, fail, busy}
  assign outs = {ref_en, div_rst_n, cp_en, locked, fail, busy};

  pll_ref_startup_seq #(
    .SETTLE_CYC       (4),
    .LOCK_WIN_CYC     (8),
    .LOCK_TIMEOUT_CYC (32),
    .UNLOCK_CYC       (3),
    .MAX_RETRY        (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .lock_raw  (lock_raw),
    .ref_en    (ref_en),
    .div_rst_n (div_rst_n),
    .cp_en     (cp_en),
    .locked    (locked),
    .fail      (fail),
    .busy      (busy),
    .state     (state),
    .retry_cnt (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls the sequence of tasks.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance to 1 time unit after edge n (edge 0 = first edge after cur=-1).
  task automatic to_edge(input int n);
    while (cur < n) begin
      @(posedge clk);
      #1;
      cur++;
    end
  endtask

  // From IDLE with lock_raw held high and synchronizer full: nominal timing.
  task automatic run_nominal(input string tag);
    start = 1'b1;
    cur   = -1;
    to_edge(0);
    vec++; if (state !== 3'd1) begin errs++; $display("[TB] FAIL %s_e0_state: got %0d want 1", tag, state); end
    vec++; if (outs !== 6'b100001) begin errs++; $display("[TB] FAIL %s_e0_outs: got %b want 100001", tag, outs); end
    to_edge(1);
    vec++; if (state !== 3'd2) begin errs++; $display("[TB] FAIL %s_e1_state: got %0d want 2", tag, state); end
    to_edge(4);
    vec++; if (outs !== 6'b100001) begin errs++; $display("[TB] FAIL %s_e4_outs: got %b want 100001", tag, outs); end
    to_edge(5);
    vec++; if (state !== 3'd3) begin errs++; $display("[TB] FAIL %s_e5_state: got %0d want 3", tag, state); end
    vec++; if (outs !== 6'b111001) begin errs++; $display("[TB] FAIL %s_e5_outs: got %b want 111001", tag, outs); end
    to_edge(12);
    vec++; if (state !== 3'd3) begin errs++; $display("[TB] FAIL %s_e12_state: got %0d want 3", tag, state); end
    to_edge(13);
    vec++; if (state !== 3'd4) begin errs++; $display("[TB] FAIL %s_e13_state: got %0d want 4", tag, state); end
    vec++; if (outs !== 6'b111100) begin errs++; $display("[TB] FAIL %s_e13_outs: got %b want 111100", tag, outs); end
    vec++; if (retry_cnt !== 2'd0) begin errs++; $display("[TB] FAIL %s_e13_retry: got %0d want 0", tag, retry_cnt); end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b1;
    lock_raw = 1'b1;
    tick(3);
    vec++; if (state !== 3'd0) begin errs++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
    vec++; if (outs !== 6'b000000) begin errs++; $display("[TB] FAIL reset_outs: got %b want 000000", outs); end
    vec++; if (retry_cnt !== 2'd0) begin errs++; $display("[TB] FAIL reset_retry: got %0d want 0", retry_cnt); end
    start = 1'b0;
    rst_n = 1'b1;
    tick(2);
    vec++; if (state !== 3'd0) begin errs++; $display("[TB] FAIL reset_idle_no_start: got %0d want 0", state); end
  endtask

  task automatic test_nominal();
    lock_raw = 1'b1;
    start    = 1'b0;
    tick(3);
    run_nominal("nominal");
  endtask

  // Runs from LOCKED with retry_cnt 0.
  task automatic test_glitch();
    lock_raw = 1'b0;
    tick(2);
    lock_raw = 1'b1;
    tick(6);
    vec++; if (state !== 3'd4) begin errs++; $display("[TB] FAIL glitch2_state: got %0d want 4", state); end
    vec++; if (locked !== 1'b1) begin errs++; $display("[TB] FAIL glitch2_locked: got %b want 1", locked); end
    lock_raw = 1'b0;
    cur      = -1;
    to_edge(2);
    lock_raw = 1'b1;
    to_edge(3);
    vec++; if (state !== 3'd4) begin errs++; $display("[TB] FAIL glitch3_e3_state: got %0d want 4", state); end
    to_edge(4);
    vec++; if (state !== 3'd5) begin errs++; $display("[TB] FAIL glitch3_e4_state: got %0d want 5", state); end
    vec++; if (retry_cnt !== 2'd1) begin errs++; $display("[TB] FAIL glitch3_retry: got %0d want 1", retry_cnt); end
    vec++; if (div_rst_n !== 1'b0) begin errs++; $display("[TB] FAIL glitch3_div_rst_n: got %b want 0", div_rst_n); end
    to_edge(8);
    vec++; if (state !== 3'd3) begin errs++; $display("[TB] FAIL glitch3_reacquire: got %0d want 3", state); end
    to_edge(16);
    vec++; if (state !== 3'd4) begin errs++; $display("[TB] FAIL glitch3_relock: got %0d want 4", state); end
    vec++; if (retry_cnt !== 2'd1) begin errs++; $display("[TB] FAIL glitch3_relock_retry: got %0d want 1", retry_cnt); end
  endtask

  task automatic test_never_locks();
    start    = 1'b0;
    lock_raw = 1'b0;
    tick(3);
    start = 1'b1;
    cur   = -1;
    to_edge(36);
    vec++; if (state !== 3'd3) begin errs++; $display("[TB] FAIL nolock_e36_state: got %0d want 3", state); end
    to_edge(37);
    vec++; if (state !== 3'd5) begin errs++; $display("[TB] FAIL nolock_e37_state: got %0d want 5", state); end
    vec++; if (retry_cnt !== 2'd1) begin errs++; $display("[TB] FAIL nolock_e37_retry: got %0d want 1", retry_cnt); end
    to_edge(41);
    vec++; if (state !== 3'd3) begin errs++; $display("[TB] FAIL nolock_e41_state: got %0d want 3", state); end
    to_edge(73);
    vec++; if (state !== 3'd5) begin errs++; $display("[TB] FAIL nolock_e73_state: got %0d want 5", state); end
    vec++; if (retry_cnt !== 2'd2) begin errs++; $display("[TB] FAIL nolock_e73_retry: got %0d want 2", retry_cnt); end
    to_edge(77);
    vec++; if (state !== 3'd3) begin errs++; $display("[TB] FAIL nolock_e77_state: got %0d want 3", state); end
    to_edge(108);
    vec++; if (state !== 3'd3) begin errs++; $display("[TB] FAIL nolock_e108_state: got %0d want 3", state); end
    to_edge(109);
    vec++; if (state !== 3'd6) begin errs++; $display("[TB] FAIL nolock_e109_state: got %0d want 6", state); end
    vec++; if (outs !== 6'b000010) begin errs++; $display("[TB] FAIL nolock_e109_outs: got %b want 000010", outs); end
    vec++; if (retry_cnt !== 2'd2) begin errs++; $display("[TB] FAIL nolock_e109_retry: got %0d want 2", retry_cnt); end
    to_edge(112);
    vec++; if (state !== 3'd6) begin errs++; $display("[TB] FAIL nolock_hold_state: got %0d want 6", state); end
    start = 1'b0;
    to_edge(113);
    vec++; if (state !== 3'd0) begin errs++; $display("[TB] FAIL nolock_release_state: got %0d want 0", state); end
    vec++; if (outs !== 6'b000000) begin errs++; $display("[TB] FAIL nolock_release_outs: got %b want 000000", outs); end
  endtask

  task automatic test_abort();
    start    = 1'b0;
    lock_raw = 1'b0;
    tick(3);
    start = 1'b1;
    cur   = -1;
    to_edge(37);
    vec++; if (retry_cnt !== 2'd1) begin errs++; $display("[TB] FAIL abort_pre_retry: got %0d want 1", retry_cnt); end
    to_edge(45);
    vec++; if (state !== 3'd3) begin errs++; $display("[TB] FAIL abort_pre_state: got %0d want 3", state); end
    start = 1'b0;
    to_edge(46);
    vec++; if (state !== 3'd0) begin errs++; $display("[TB] FAIL abort_state: got %0d want 0", state); end
    vec++; if (outs !== 6'b000000) begin errs++; $display("[TB] FAIL abort_outs: got %b want 000000", outs); end
    vec++; if (retry_cnt !== 2'd0) begin errs++; $display("[TB] FAIL abort_retry: got %0d want 0", retry_cnt); end
    lock_raw = 1'b1;
    tick(3);
    run_nominal("abort_restart");
  endtask

  task automatic test_collision();
    start    = 1'b0;
    lock_raw = 1'b0;
    tick(3);
    start = 1'b1;
    cur   = -1;
    to_edge(27);
    lock_raw = 1'b1;
    to_edge(36);
    vec++; if (state !== 3'd3) begin errs++; $display("[TB] FAIL collide_e36_state: got %0d want 3", state); end
    to_edge(37);
    vec++; if (state !== 3'd4) begin errs++; $display("[TB] FAIL collide_e37_state: got %0d want 4", state); end
    vec++; if (retry_cnt !== 2'd0) begin errs++; $display("[TB] FAIL collide_e37_retry: got %0d want 0", retry_cnt); end
    // One cycle later the window is short by one and the timeout wins.
    start    = 1'b0;
    lock_raw = 1'b0;
    tick(3);
    start = 1'b1;
    cur   = -1;
    to_edge(28);
    lock_raw = 1'b1;
    to_edge(37);
    vec++; if (state !== 3'd5) begin errs++; $display("[TB] FAIL nearmiss_e37_state: got %0d want 5", state); end
    vec++; if (retry_cnt !== 2'd1) begin errs++; $display("[TB] FAIL nearmiss_e37_retry: got %0d want 1", retry_cnt); end
    to_edge(49);
    vec++; if (state !== 3'd4) begin errs++; $display("[TB] FAIL nearmiss_e49_state: got %0d want 4", state); end
  endtask

  // Runs from LOCKED with retry_cnt 1.
  task automatic test_async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    vec++; if (state !== 3'd0) begin errs++; $display("[TB] FAIL areset_state: got %0d want 0", state); end
    vec++; if (outs !== 6'b000000) begin errs++; $display("[TB] FAIL areset_outs: got %b want 000000", outs); end
    vec++; if (retry_cnt !== 2'd0) begin errs++; $display("[TB] FAIL areset_retry: got %0d want 0", retry_cnt); end
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(3);
    run_nominal("post_reset");
  endtask

  initial begin
    $display("[TB] pll_ref_startup_seq directed test start");
    test_reset();
    test_nominal();
    test_glitch();
    test_never_locks();
    test_abort();
    test_collision();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
